// File: rtl/eth_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module   : eth_tx_framer
//  Purpose  : Buffers upstream IP packets in a committed-write FIFO and emits
//             GMII-style Ethernet II frames (preamble/SFD/header/pad/FCS/IFG).
//  Revision : 1.0  initial release
// ============================================================================
module eth_tx_framer #(
    parameter logic [47:0] DST_MAC = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC = 48'h0200_0000_0001,
    parameter int          FIFO_AW = 11,
    parameter int          IFG_LEN = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    input  logic       wr_first,
    input  logic       wr_last,
    input  logic [7:0] wrdata,
    output logic [7:0] txd,
    output logic       tx_en,
    output logic       busy,
    output logic       overflow
);

    localparam int              DEPTH    = 1 << FIFO_AW;
    localparam int              PW       = FIFO_AW + 1;
    localparam int              LEN_W    = FIFO_AW + 2;
    localparam int              IDX_W    = 16;
    localparam logic [111:0]    HDR      = {DST_MAC, SRC_MAC, 16'h0800};
    localparam logic [31:0]     CRC_POLY = 32'hEDB8_8320;
    localparam logic [31:0]     CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(60);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_SFD      = 3'd2,
        S_HEADER   = 3'd3,
        S_PAYLOAD  = 3'd4,
        S_PAD      = 3'd5,
        S_FCS      = 3'd6,
        S_IFG      = 3'd7
    } state_t;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [7:0] hdr_byte(input logic [3:0] i);
        return HDR[8*(13 - int'(i)) +: 8];
    endfunction

    function automatic logic [7:0] fcs_byte(input logic [31:0] c, input logic [1:0] sel);
        logic [31:0] f;
        f = ~c;
        return f[8*int'(sel) +: 8];
    endfunction

    // Each entry holds {last_flag, data} so the reader finds packet ends.
    logic [8:0]          mem [DEPTH];
    logic [8:0]          rd_data;

    logic [PW-1:0]       wr_spec_q, wr_spec_d;
    logic [PW-1:0]       wr_commit_q, wr_commit_d;
    logic [PW-1:0]       rd_q, rd_d;
    logic [PW-1:0]       pkt_cnt_q, pkt_cnt_d;
    logic                open_q, open_d;
    logic                drop_q, drop_d;
    logic                overflow_q, overflow_d;

    logic                mem_we;
    logic [FIFO_AW-1:0]  mem_waddr;
    logic [8:0]          mem_wdata;
    logic [PW-1:0]       wr_base;
    logic                pkt_inc;
    logic                pkt_dec;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                last_q, last_d;
    logic [31:0]         crc_q, crc_d;
    logic [7:0]          txd_q, txd_d;
    logic                tx_en_q, tx_en_d;

    logic                data_emit;
    logic [7:0]          data_byte;
    logic                pay_read;
    logic                start_fcs;
    logic                start_frame;

    assign rd_data = mem[rd_q[FIFO_AW-1:0]];

    // Write side: bytes land at the speculative pointer; only wr_last publishes them.
    always_comb begin
        wr_spec_d   = wr_spec_q;
        wr_commit_d = wr_commit_q;
        open_d      = open_q;
        drop_d      = drop_q;
        overflow_d  = overflow_q;
        mem_we      = 1'b0;
        mem_waddr   = wr_spec_q[FIFO_AW-1:0];
        mem_wdata   = {wr_last, wrdata};
        pkt_inc     = 1'b0;
        wr_base     = wr_first ? wr_commit_q : wr_spec_q;

        if (wr_valid) begin
            if (drop_q) begin
                if (wr_last) begin
                    drop_d = 1'b0;
                end
            end else if (wr_first || open_q) begin
                if ((wr_base - rd_q) == PW'(DEPTH)) begin
                    wr_spec_d  = wr_commit_q;
                    overflow_d = 1'b1;
                    open_d     = 1'b0;
                    drop_d     = !wr_last;
                end else begin
                    mem_we    = 1'b1;
                    mem_waddr = wr_base[FIFO_AW-1:0];
                    wr_spec_d = wr_base + PW'(1);
                    if (wr_last) begin
                        wr_commit_d = wr_base + PW'(1);
                        open_d      = 1'b0;
                        pkt_inc     = 1'b1;
                    end else begin
                        open_d = 1'b1;
                    end
                end
            end
        end
    end

    // Transmit side: the registered outputs always carry the byte for the state being entered.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        last_d      = last_q;
        crc_d       = crc_q;
        rd_d        = rd_q;
        txd_d       = 8'h00;
        tx_en_d     = 1'b0;
        pkt_dec     = 1'b0;
        data_emit   = 1'b0;
        data_byte   = 8'h00;
        pay_read    = 1'b0;
        start_fcs   = 1'b0;
        start_frame = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pkt_cnt_q != '0) begin
                    start_frame = 1'b1;
                end
            end
            S_PREAMBLE: begin
                tx_en_d = 1'b1;
                if (idx_q == IDX_W'(6)) begin
                    state_d = S_SFD;
                    txd_d   = 8'hD5;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                    txd_d = 8'h55;
                end
            end
            S_SFD: begin
                state_d   = S_HEADER;
                idx_d     = '0;
                data_emit = 1'b1;
                data_byte = hdr_byte(4'd0);
            end
            S_HEADER: begin
                if (idx_q == IDX_W'(13)) begin
                    state_d  = S_PAYLOAD;
                    pay_read = 1'b1;
                end else begin
                    idx_d     = idx_q + IDX_W'(1);
                    data_emit = 1'b1;
                    data_byte = hdr_byte(idx_q[3:0] + 4'd1);
                end
            end
            S_PAYLOAD: begin
                if (!last_q) begin
                    pay_read = 1'b1;
                end else if (len_q < MIN_LEN) begin
                    state_d   = S_PAD;
                    data_emit = 1'b1;
                end else begin
                    start_fcs = 1'b1;
                end
            end
            S_PAD: begin
                if (len_q < MIN_LEN) begin
                    data_emit = 1'b1;
                end else begin
                    start_fcs = 1'b1;
                end
            end
            S_FCS: begin
                if (idx_q == IDX_W'(3)) begin
                    state_d = S_IFG;
                    idx_d   = '0;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    tx_en_d = 1'b1;
                    txd_d   = fcs_byte(crc_q, idx_q[1:0] + 2'd1);
                end
            end
            S_IFG: begin
                // A waiting packet starts straight out of the gap so the gap stays exactly IFG_LEN.
                if (idx_q == IDX_W'(IFG_LEN - 1)) begin
                    if (pkt_cnt_q != '0) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (start_frame) begin
            state_d = S_PREAMBLE;
            idx_d   = '0;
            len_d   = '0;
            crc_d   = CRC_INIT;
            txd_d   = 8'h55;
            tx_en_d = 1'b1;
        end

        if (pay_read) begin
            data_emit = 1'b1;
            data_byte = rd_data[7:0];
            last_d    = rd_data[8];
            rd_d      = rd_q + PW'(1);
            pkt_dec   = rd_data[8];
        end

        if (start_fcs) begin
            state_d = S_FCS;
            idx_d   = '0;
            txd_d   = fcs_byte(crc_q, 2'd0);
            tx_en_d = 1'b1;
        end

        if (data_emit) begin
            txd_d   = data_byte;
            tx_en_d = 1'b1;
            crc_d   = crc_byte(crc_q, data_byte);
            len_d   = len_q + LEN_W'(1);
        end
    end

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        case ({pkt_inc, pkt_dec})
            2'b10:   pkt_cnt_d = pkt_cnt_q + PW'(1);
            2'b01:   pkt_cnt_d = pkt_cnt_q - PW'(1);
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_spec_q   <= '0;
            wr_commit_q <= '0;
            rd_q        <= '0;
            pkt_cnt_q   <= '0;
            open_q      <= 1'b0;
            drop_q      <= 1'b0;
            overflow_q  <= 1'b0;
            state_q     <= S_IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            last_q      <= 1'b0;
            crc_q       <= CRC_INIT;
            txd_q       <= 8'h00;
            tx_en_q     <= 1'b0;
        end else begin
            wr_spec_q   <= wr_spec_d;
            wr_commit_q <= wr_commit_d;
            rd_q        <= rd_d;
            pkt_cnt_q   <= pkt_cnt_d;
            open_q      <= open_d;
            drop_q      <= drop_d;
            overflow_q  <= overflow_d;
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            last_q      <= last_d;
            crc_q       <= crc_d;
            txd_q       <= txd_d;
            tx_en_q     <= tx_en_d;
        end
    end

    assign txd      = txd_q;
    assign tx_en    = tx_en_q;
    assign busy     = (state_q != S_IDLE);
    assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_eth_tx_framer
//  Purpose  : Scoreboard bench for eth_tx_framer with a frame-level reference.
//  Revision : 1.0  initial release
// ============================================================================
module tb_eth_tx_framer;

    localparam logic [47:0] C_DST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] C_SRC = 48'h0200_0000_0001;
    localparam int          C_IFG = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_first = 1'b0;
    logic       wr_last = 1'b0;
    logic [7:0] wrdata = 8'h00;
    logic [7:0] txd;
    logic       tx_en;
    logic       busy;
    logic       overflow;

    eth_tx_framer #(
        .DST_MAC (C_DST),
        .SRC_MAC (C_SRC),
        .FIFO_AW (11),
        .IFG_LEN (C_IFG)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_first (wr_first),
        .wr_last  (wr_last),
        .wrdata   (wrdata),
        .txd      (txd),
        .tx_en    (tx_en),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    logic [7:0] pkt[$];
    logic [7:0] exp_bytes[$];
    int         exp_len[$];
    bit         exp_tight[$];

    logic [7:0] cur[$];
    bit         in_frame = 1'b0;
    bit         have_prev = 1'b0;
    int         gap = 0;
    int         start_gap = 0;
    int         zero_viol = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < 8; k++) begin
            if (r[0] ^ b[k]) r = (r >> 1) ^ 32'hEDB8_8320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // Reference frame: header + payload zero-padded to 60, CRC over that, framed by preamble/SFD.
    task automatic push_expected(input bit tight);
        logic [7:0]  d[$];
        logic [31:0] c;
        for (int k = 5; k >= 0; k--) d.push_back(C_DST[8*k +: 8]);
        for (int k = 5; k >= 0; k--) d.push_back(C_SRC[8*k +: 8]);
        d.push_back(8'h08);
        d.push_back(8'h00);
        foreach (pkt[i]) d.push_back(pkt[i]);
        while (d.size() < 60) d.push_back(8'h00);
        c = 32'hFFFF_FFFF;
        foreach (d[i]) c = crc_step(c, d[i]);
        c = ~c;
        exp_len.push_back(8 + d.size() + 4);
        exp_tight.push_back(tight);
        for (int k = 0; k < 7; k++) exp_bytes.push_back(8'h55);
        exp_bytes.push_back(8'hD5);
        foreach (d[i]) exp_bytes.push_back(d[i]);
        for (int k = 0; k < 4; k++) exp_bytes.push_back(c[8*k +: 8]);
    endtask

    task automatic compare_frame();
        int          n;
        int          mism;
        bit          tight;
        logic [7:0]  e;
        logic [31:0] r;
        if (exp_len.size() == 0) begin
            check("unexpected_frame_len", cur.size(), 0);
            return;
        end
        n     = exp_len.pop_front();
        tight = exp_tight.pop_front();
        check("frame_len", cur.size(), n);
        mism = 0;
        for (int i = 0; i < n; i++) begin
            e = exp_bytes.pop_front();
            if (i >= cur.size() || cur[i] !== e) mism++;
        end
        check("frame_bytes_mismatched", mism, 0);
        if (cur.size() > 12) begin
            r = 32'hFFFF_FFFF;
            for (int i = 8; i < cur.size(); i++) r = crc_step(r, cur[i]);
            check("fcs_residue", r, 32'hDEBB_20E3);
        end
        if (have_prev) check("ifg_min", (start_gap >= C_IFG), 1);
        if (tight)     check("ifg_exact", start_gap, C_IFG);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            cur.delete();
            in_frame  = 1'b0;
            have_prev = 1'b0;
            gap       = 0;
        end else if (tx_en) begin
            if (!in_frame) begin
                in_frame  = 1'b1;
                start_gap = gap;
            end
            cur.push_back(txd);
        end else begin
            if (txd !== 8'h00) zero_viol++;
            if (in_frame) begin
                in_frame = 1'b0;
                compare_frame();
                cur.delete();
                have_prev = 1'b1;
                gap = 1;
            end else begin
                gap++;
            end
        end
    end

    task automatic drive_pkt(input bit expect_tx, input bit tight, input bit with_last);
        int n;
        n = pkt.size();
        if (expect_tx) push_expected(tight);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            wr_valid = 1'b1;
            wr_first = (i == 0);
            wr_last  = with_last && (i == n - 1);
            wrdata   = pkt[i];
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        wr_first = 1'b0;
        wr_last  = 1'b0;
        wrdata   = 8'h00;
        repeat (n) @(posedge clk);
    endtask

    task automatic fill_rand(input int n);
        pkt.delete();
        for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
    endtask

    task automatic wait_drain(input int max_cycles);
        int k;
        for (k = 0; k < max_cycles; k++) begin
            @(negedge clk);
            if (exp_len.size() == 0 && !busy) break;
        end
        check("drain_within_budget", (k < max_cycles), 1);
    endtask

    initial begin
        int k;
        int hi_cnt;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_txd", txd, 8'h00);
        check("reset_tx_en", tx_en, 0);
        check("reset_busy", busy, 0);
        check("reset_overflow", overflow, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 20-byte packet 0x45, 0x46, ... (padded frame)
        pkt.delete();
        for (int i = 0; i < 20; i++) pkt.push_back(8'h45 + 8'(i));
        drive_pkt(1, 0, 1);
        idle(1);
        wait_drain(400);

        // 100-byte packet, no pad
        fill_rand(100);
        drive_pkt(1, 0, 1);
        idle(1);
        wait_drain(400);

        // two 30-byte packets with no idle between writes
        fill_rand(30);
        drive_pkt(1, 0, 1);
        fill_rand(30);
        drive_pkt(1, 1, 1);
        idle(1);
        wait_drain(600);

        // oversized packet into an empty FIFO, then a normal one
        fill_rand(2100);
        drive_pkt(0, 0, 1);
        idle(2);
        check("overflow_sticky_set", overflow, 1);
        fill_rand(20);
        drive_pkt(1, 0, 1);
        idle(1);
        wait_drain(400);

        // restart: 5 bytes left open, then a fresh 10-byte packet
        fill_rand(5);
        drive_pkt(0, 0, 0);
        fill_rand(10);
        drive_pkt(1, 0, 1);
        idle(1);
        wait_drain(400);

        // reset in the middle of the header
        fill_rand(50);
        drive_pkt(1, 0, 1);
        idle(0);
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (tx_en) break;
        end
        check("tx_start_within_budget", (k < 200), 1);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        exp_len.delete();
        exp_bytes.delete();
        exp_tight.delete();
        #1;
        check("midreset_tx_en", tx_en, 0);
        check("midreset_busy", busy, 0);
        check("midreset_overflow", overflow, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        hi_cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx_en || busy) hi_cnt++;
        end
        check("quiet_after_reset", hi_cnt, 0);

        // randomized packets, including a 1-byte packet, written while frames are going out
        for (int p = 0; p < 10; p++) begin
            fill_rand((p == 0) ? 1 : int'($urandom_range(1, 120)));
            drive_pkt(1, 0, 1);
            idle(int'($urandom_range(0, 4)));
        end
        wait_drain(5000);

        check("scoreboard_empty", exp_len.size(), 0);
        check("txd_zero_while_idle", zero_viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
